// File: rtl/i2s_slave_tx.sv
// I2S slave transmitter: follows an external sck/ws and shifts a stereo pair out on sd, MSB first,
// one sck after each word-select transition. Pairs arrive over a valid/ready handshake.
module i2s_slave_tx #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLOT  = 32
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             sck,
    input  logic             ws,
    output logic             sd,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    input  logic             valid,
    output logic             ready,
    output logic             underrun,
    output logic             frame_err
);
    localparam int unsigned CW = 6;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    state_t           state, state_n;
    logic             sck_meta, sck_sync, sck_last;
    logic             ws_meta, ws_sync, ws_prev;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] hold_l, hold_l_n, hold_r, hold_r_n;
    logic [WIDTH-1:0] shift_l, shift_l_n, shift_r, shift_r_n;
    logic             sd_n, ready_n, underrun_n, frame_err_n;
    logic             rise, fall, slot_start, enter_left;

    assign rise       = sck_sync & ~sck_last;
    assign fall       = ~sck_sync & sck_last;
    assign slot_start = rise & (ws_sync != ws_prev);

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) state <= SYNC;
        else        state <= state_n;
    end

    // Next state, slot bookkeeping, shifter and handshake.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        hold_l_n    = hold_l;
        hold_r_n    = hold_r;
        shift_l_n   = shift_l;
        shift_r_n   = shift_r;
        sd_n        = sd;
        ready_n     = ready;
        underrun_n  = 1'b0;
        frame_err_n = 1'b0;
        enter_left  = 1'b0;

        if (slot_start) begin
            cnt_n = '0;
            if (state == SYNC) begin
                if (!ws_sync) begin
                    state_n    = LEFT;
                    enter_left = 1'b1;
                end
            end else begin
                if (cnt != CW'(SLOT)) frame_err_n = 1'b1;
                state_n    = ws_sync ? RIGHT : LEFT;
                enter_left = ~ws_sync;
            end
        end else if (fall && state != SYNC) begin
            if (cnt != CNT_MAX) cnt_n = cnt + CW'(1);
            if (cnt < CW'(WIDTH)) begin
                if (state == LEFT) begin
                    sd_n      = shift_l[WIDTH-1];
                    shift_l_n = shift_l << 1;
                end else begin
                    sd_n      = shift_r[WIDTH-1];
                    shift_r_n = shift_r << 1;
                end
            end else begin
                sd_n = 1'b0;
            end
        end

        // Transfer uses the holding contents as they stood before any same-cycle load.
        if (enter_left) begin
            if (!ready) begin
                shift_l_n = hold_l;
                shift_r_n = hold_r;
                ready_n   = 1'b1;
            end else begin
                shift_l_n  = '0;
                shift_r_n  = '0;
                underrun_n = 1'b1;
            end
        end

        if (valid && ready) begin
            hold_l_n = left;
            hold_r_n = right;
            ready_n  = 1'b0;
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_last  <= 1'b0;
            ws_meta   <= 1'b0;
            ws_sync   <= 1'b0;
            ws_prev   <= 1'b0;
            cnt       <= '0;
            hold_l    <= '0;
            hold_r    <= '0;
            shift_l   <= '0;
            shift_r   <= '0;
            sd        <= 1'b0;
            ready     <= 1'b1;
            underrun  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sck_meta  <= sck;
            sck_sync  <= sck_meta;
            sck_last  <= sck_sync;
            ws_meta   <= ws;
            ws_sync   <= ws_meta;
            if (rise) ws_prev <= ws_sync;
            cnt       <= cnt_n;
            hold_l    <= hold_l_n;
            hold_r    <= hold_r_n;
            shift_l   <= shift_l_n;
            shift_r   <= shift_r_n;
            sd        <= sd_n;
            ready     <= ready_n;
            underrun  <= underrun_n;
            frame_err <= frame_err_n;
        end
    end

endmodule

// File: tb/tb_i2s_slave_tx.sv
// Bench for i2s_slave_tx: an I2S master model drives sck/ws and captures sd; a frame-level
// reference model predicts each slot's word, and a monitor scores captured slots against it.
module tb_i2s_slave_tx;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned SLOT  = 32;
    localparam int unsigned NSLOT = 22;

    logic             ck = 1'b0;
    logic             rst_n = 1'b0;
    logic             sck = 1'b1;
    logic             ws = 1'b1;
    logic             valid = 1'b0;
    logic [WIDTH-1:0] left = '0;
    logic [WIDTH-1:0] right = '0;
    logic             sd, ready, underrun, frame_err;

    i2s_slave_tx #(.WIDTH(WIDTH), .SLOT(SLOT)) dut (
        .ck(ck), .rst_n(rst_n), .sck(sck), .ws(ws), .sd(sd),
        .left(left), .right(right), .valid(valid), .ready(ready),
        .underrun(underrun), .frame_err(frame_err)
    );

    always #5 ck = ~ck;

    typedef struct { bit w; int len; bit chk; } slot_t;
    typedef struct { bit w; logic [15:0] word; bit tail_zero; } obs_t;
    typedef struct { logic [15:0] l; logic [15:0] r; } pair_t;

    slot_t plan[$];
    obs_t  obs_q[$];
    obs_t  exp_q[$];
    pair_t pend[$];

    int checks = 0, errors = 0;
    int cur_slot = -1, cur_bit = 0;
    int exp_under = 0, exp_ferr = 0, got_under = 0, got_ferr = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic wait_pos(input int s, input int b);
        int n = 0;
        while (!(cur_slot > s || (cur_slot == s && cur_bit >= b)) && n < 20000) begin
            @(negedge ck);
            n++;
        end
        if (n >= 20000) begin
            checks++;
            errors++;
            $display("FAIL wait_pos: timed out at slot %0d bit %0d, wanted slot %0d bit %0d",
                     cur_slot, cur_bit, s, b);
        end
    endtask

    // Present a pair and hold it until accepted; the model records it at the accepting edge.
    task automatic send(input logic [15:0] l, input logic [15:0] r);
        int n = 0;
        pair_t p;
        @(negedge ck);
        valid = 1'b1;
        left  = l;
        right = r;
        while (ready !== 1'b1 && n < 2000) begin
            @(negedge ck);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL send: ready never rose for pair %h/%h", l, r);
        end else begin
            @(posedge ck);
            p.l = l;
            p.r = r;
            pend.push_back(p);
        end
        @(negedge ck);
        valid = 1'b0;
    endtask

    always @(negedge ck) begin
        if (underrun === 1'b1)  got_under++;
        if (frame_err === 1'b1) got_ferr++;
    end

    // Master: one sck period = 8 ck; ws changes on the fall before each slot's first rise.
    initial begin : master
        slot_t       s;
        pair_t       p;
        obs_t        o, e;
        logic [15:0] w, ew, m_r;
        logic        b;
        bit          tz, m_ws, m_hunt;
        int          m_prev_len;
        m_ws = 1'b1;
        m_hunt = 1'b1;
        m_prev_len = SLOT;
        m_r = '0;
        forever begin
            if (plan.size() == 0) begin
                @(negedge ck);
                continue;
            end
            s = plan.pop_front();
            cur_slot++;
            cur_bit = 0;
            ew = '0;
            if (s.w != m_ws) begin
                if (!m_hunt && m_prev_len != SLOT) exp_ferr++;
                if (!s.w) begin
                    m_hunt = 1'b0;
                    if (pend.size() > 0) begin
                        p   = pend.pop_front();
                        ew  = p.l;
                        m_r = p.r;
                    end else begin
                        m_r = '0;
                        exp_under++;
                    end
                end else begin
                    ew = m_hunt ? 16'h0 : m_r;
                end
            end
            m_ws = s.w;
            m_prev_len = s.len;
            if (s.chk) begin
                e.w = s.w;
                e.word = ew;
                e.tail_zero = 1'b1;
                exp_q.push_back(e);
            end
            w  = '0;
            tz = 1'b1;
            for (int k = 0; k < s.len; k++) begin
                cur_bit = k;
                sck = 1'b0;
                if (k == 0) ws = s.w;
                repeat (4) @(negedge ck);
                b = sd;
                if (k >= 1 && k <= WIDTH) w = {w[14:0], b};
                else if (k > WIDTH && b !== 1'b0) tz = 1'b0;
                sck = 1'b1;
                repeat (4) @(negedge ck);
            end
            if (s.chk) begin
                o.w = s.w;
                o.word = w;
                o.tail_zero = tz;
                obs_q.push_back(o);
            end
        end
    end

    initial begin : monitor
        obs_t o, e;
        forever begin
            @(negedge ck);
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL slot_order: captured word %h with no prediction", o.word);
                end else begin
                    e = exp_q.pop_front();
                    check(o.w ? "right_word" : "left_word", 32'(o.word), 32'(e.word));
                    check("tail_zero", 32'(o.tail_zero), 32'(e.tail_zero));
                end
            end
        end
    end

    initial begin : stim
        slot_t s;
        logic [15:0] vals[4];
        vals[0] = 16'h0001; vals[1] = 16'h8000; vals[2] = 16'hFFFF; vals[3] = 16'h1234;
        for (int i = 0; i < int'(NSLOT); i++) begin
            s.w   = (i % 2 == 0);
            s.len = (i == 15) ? 30 : int'(SLOT);
            s.chk = (i != int'(NSLOT) - 1);
            plan.push_back(s);
        end

        // Reset held with sck running.
        wait_pos(0, 6);
        check("reset_sd", 32'(sd), 32'd0);
        check("reset_ready", 32'(ready), 32'd1);
        @(negedge ck);
        rst_n = 1'b1;

        // Normal frame.
        wait_pos(0, 10);
        send(16'hA5C3, 16'h0F01);
        check("ready_after_load", 32'(ready), 32'(pend.size() == 0));
        wait_pos(1, 4);
        check("ready_after_xfer", 32'(ready), 32'(pend.size() == 0));

        // Back-to-back pairs loaded on each ready.
        wait_pos(2, 4);
        for (int i = 0; i < 4; i++) send(vals[i], 16'($urandom));

        // Slot 11 starts with nothing loaded: underrun, then recovery.
        wait_pos(12, 4);
        send(16'($urandom), 16'($urandom));
        wait_pos(13, 2);
        check("underrun_count", 32'(got_under), 32'(exp_under));

        // Slot 15 is shortened to 30 sck.
        wait_pos(14, 4);
        send(16'($urandom) | 16'h8000, 16'($urandom) | 16'h8000);

        // Pair waiting in holding, plus a second pair presented across the left-entry transfer.
        wait_pos(16, 4);
        send(16'($urandom), 16'($urandom));
        wait_pos(17, 0);
        send(16'($urandom), 16'($urandom));
        wait_pos(17, 2);
        check("frame_err_count", 32'(got_ferr), 32'(exp_ferr));

        // Reset in the middle of a left word of ones.
        wait_pos(20, 4);
        send(16'hFFFF, 16'($urandom));
        wait_pos(21, 8);
        check("sd_mid_word", 32'(sd), 32'd1);
        rst_n = 1'b0;
        #1;
        check("sd_async_reset", 32'(sd), 32'd0);
        check("ready_async_reset", 32'(ready), 32'd1);
        repeat (4) @(negedge ck);

        check("underrun_total", 32'(got_under), 32'(exp_under));
        check("frame_err_total", 32'(got_ferr), 32'(exp_ferr));
        check("pending_predictions", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
